// File: rtl/id_imm_ctrl_pkg.sv
// Shared constants for the decode-stage immediate controller: immediate type codes,
// RV32I opcodes, FSM state encoding and the opcode-to-type decode.
package id_imm_ctrl_pkg;

    localparam logic [2:0] NOIMM = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {
        StRun     = 1'b0,
        StLuStall = 1'b1
    } id_state_e;

    function automatic logic [2:0] imm_type_of(input logic [6:0] opc);
        logic [2:0] t;
        case (opc)
            OP_IMM, OP_LOAD, OP_JALR: t = ITYPE;
            OP_STORE:                 t = STYPE;
            OP_BRANCH:                t = BTYPE;
            OP_LUI, OP_AUIPC:         t = UTYPE;
            OP_JAL:                   t = JTYPE;
            default:                  t = NOIMM;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/id_hazard_det.sv
// Load-use hazard detect: decides which source fields the ID instruction reads and
// compares them against the destination of a load sitting in EX.
module id_hazard_det
    import id_imm_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    input  logic        vld,
    input  logic        ex_load,
    input  logic [4:0]  ex_rd,
    output logic        haz
);

    logic [6:0] opc;
    logic       use1;
    logic       use2;

    assign opc  = inst[6:0];
    assign use1 = (opc != OP_LUI) && (opc != OP_AUIPC) && (opc != OP_JAL);
    assign use2 = (opc == OP_REG) || (opc == OP_STORE) || (opc == OP_BRANCH);

    assign haz = vld && ex_load && (ex_rd != 5'd0) &&
                 ((use1 && (inst[19:15] == ex_rd)) || (use2 && (inst[24:20] == ex_rd)));

endmodule

// File: rtl/id_imm_ctrl.sv
// IF/ID register, immediate-type classification and load-use stall FSM.
// Optional performance counters are built when ID_PERF_CNT_EN is defined.
module id_imm_ctrl
    import id_imm_ctrl_pkg::*;
#(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
`ifdef ID_PERF_CNT_EN
    ,
    parameter int unsigned CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_i,
    input  logic             inst_vld_i,
    input  logic             flush_d_i,
    input  logic             hold_i,
    input  logic             ex_load_i,
    input  logic [4:0]       ex_rd_i,
    output logic [24:0]      imm_in_o,
    output logic [2:0]       imm_type_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic             id_vld_o,
    output logic             stall_f_o,
`ifdef ID_PERF_CNT_EN
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             bubble_e_o
);

    logic [31:0] inst_q, inst_d;
    logic        vld_q, vld_d;
    id_state_e   state_q, state_d;
    logic        haz;
    logic        stall;

    id_hazard_det u_haz (
        .inst    (inst_q),
        .vld     (vld_q),
        .ex_load (ex_load_i),
        .ex_rd   (ex_rd_i),
        .haz     (haz)
    );

    // A hazard seen in StLuStall is ignored: the bubble already resolved it.
    assign stall = (state_q == StRun) && haz && !flush_d_i && !hold_i;

    always_comb begin
        inst_d  = inst_q;
        vld_d   = vld_q;
        state_d = state_q;
        if (hold_i) begin
            // everything frozen
        end else if (flush_d_i) begin
            inst_d  = NOP_INST;
            vld_d   = 1'b0;
            state_d = StRun;
        end else if (stall) begin
            state_d = StLuStall;
        end else begin
            inst_d  = inst_vld_i ? inst_i : NOP_INST;
            vld_d   = inst_vld_i;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= NOP_INST;
            vld_q   <= 1'b0;
            state_q <= StRun;
        end else begin
            inst_q  <= inst_d;
            vld_q   <= vld_d;
            state_q <= state_d;
        end
    end

    assign imm_in_o   = inst_q[31:7];
    assign imm_type_o = imm_type_of(inst_q[6:0]);
    assign rs1_o      = inst_q[19:15];
    assign rs2_o      = inst_q[24:20];
    assign id_vld_o   = vld_q;
    assign stall_f_o  = stall;
    assign bubble_e_o = stall;

`ifdef ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters; stall already implies !hold_i.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_d_i && vld_q && !hold_i && !(&flush_cnt_q)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Directed bench for id_imm_ctrl: per-cycle expectations are queued as each step is
// driven and compared against the DUT outputs 1 ns later, well away from the rising edge.
module tb_id_imm_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADDI   = 32'hFFF0_0093;
    localparam logic [31:0] SW     = 32'h0011_2023; // rs1=2, rs2=1
    localparam logic [31:0] BEQ    = 32'h0000_0463;
    localparam logic [31:0] LUI    = 32'h0000_12B7;
    localparam logic [31:0] JAL    = 32'h0080_006F;
    localparam logic [31:0] ADD0   = 32'h0020_8033;
    localparam logic [31:0] ADDX6  = 32'h0072_8333; // add x6,x5,x7
    localparam logic [31:0] LUI5   = 32'h0002_82B7; // lui x5 with [19:15]=5

    localparam logic [2:0] T_NO = 3'd0;
    localparam logic [2:0] T_I  = 3'd1;
    localparam logic [2:0] T_S  = 3'd2;
    localparam logic [2:0] T_B  = 3'd3;
    localparam logic [2:0] T_U  = 3'd4;
    localparam logic [2:0] T_J  = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] inst_i = '0;
    logic        inst_vld_i = 1'b0;
    logic        flush_d_i = 1'b0;
    logic        hold_i = 1'b0;
    logic        ex_load_i = 1'b0;
    logic [4:0]  ex_rd_i = '0;
    logic [24:0] imm_in;
    logic [2:0]  imm_type;
    logic [4:0]  rs1, rs2;
    logic        id_vld, stall_f, bubble_e;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        string       tag;
        logic [31:0] inst;
        logic [2:0]  ty;
        logic        vld;
        logic        stall;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    id_imm_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inst_i     (inst_i),
        .inst_vld_i (inst_vld_i),
        .flush_d_i  (flush_d_i),
        .hold_i     (hold_i),
        .ex_load_i  (ex_load_i),
        .ex_rd_i    (ex_rd_i),
        .imm_in_o   (imm_in),
        .imm_type_o (imm_type),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .id_vld_o   (id_vld),
        .stall_f_o  (stall_f),
`ifdef ID_PERF_CNT_EN
        .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt),
`endif
        .bubble_e_o (bubble_e)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] in, input logic fl, input logic ho,
                         input logic ld, input logic [4:0] rd);
        inst_vld_i = iv;
        inst_i     = in;
        flush_d_i  = fl;
        hold_i     = ho;
        ex_load_i  = ld;
        ex_rd_i    = rd;
    endtask

    // Queue the expected IF/ID view for this cycle, then compare once outputs settle.
    task automatic expect_now(input string tag, input logic [31:0] e_inst, input logic [2:0] e_ty,
                              input logic e_vld, input logic e_stall);
        exp_t e;
        sbq.push_back('{tag, e_inst, e_ty, e_vld, e_stall});
        #1;
        e = sbq.pop_front();
        cmp({e.tag, ".imm_in"}, 32'(imm_in), 32'(e.inst[31:7]));
        cmp({e.tag, ".type"},   32'(imm_type), 32'(e.ty));
        cmp({e.tag, ".rs1"},    32'(rs1), 32'(e.inst[19:15]));
        cmp({e.tag, ".rs2"},    32'(rs2), 32'(e.inst[24:20]));
        cmp({e.tag, ".id_vld"}, 32'(id_vld), 32'(e.vld));
        cmp({e.tag, ".stall"},  32'(stall_f), 32'(e.stall));
        cmp({e.tag, ".bubble"}, 32'(bubble_e), 32'(e.stall));
    endtask

    task automatic step(input string tag, input logic iv, input logic [31:0] in, input logic fl,
                        input logic ho, input logic ld, input logic [4:0] rd,
                        input logic [31:0] e_inst, input logic [2:0] e_ty, input logic e_vld,
                        input logic e_stall);
        drive(iv, in, fl, ho, ld, rd);
        expect_now(tag, e_inst, e_ty, e_vld, e_stall);
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        step("rst",        1, ADDI,  0, 0, 0, 5'd0, NOP,   T_I,  0, 0);
        rst_n = 1'b1;
        step("idle0",      0, ADDI,  0, 0, 0, 5'd0, NOP,   T_I,  0, 0);
        step("idle1",      1, ADDI,  0, 0, 0, 5'd0, NOP,   T_I,  0, 0);
        step("addi",       1, SW,    0, 0, 0, 5'd0, ADDI,  T_I,  1, 0);
        step("sw",         1, BEQ,   0, 0, 0, 5'd0, SW,    T_S,  1, 0);
        step("beq",        1, LUI,   0, 0, 0, 5'd0, BEQ,   T_B,  1, 0);
        step("lui",        1, JAL,   0, 0, 0, 5'd0, LUI,   T_U,  1, 0);
        step("jal",        1, ADD0,  0, 0, 0, 5'd0, JAL,   T_J,  1, 0);
        step("add",        1, ADDX6, 0, 0, 0, 5'd0, ADD0,  T_NO, 1, 0);
        // load-use on x5: one stall cycle, IF/ID held, second hazard ignored
        step("lu_stall",   1, ADDI,  0, 0, 1, 5'd5, ADDX6, T_NO, 1, 1);
        step("lu_after",   1, ADDI,  0, 0, 1, 5'd5, ADDX6, T_NO, 1, 0);
        step("post_lu",    1, ADDX6, 0, 0, 0, 5'd0, ADDI,  T_I,  1, 0);
        // false-hazard checks
        step("rd_x0",      1, LUI5,  0, 0, 1, 5'd0, ADDX6, T_NO, 1, 0);
        step("lui_nohaz",  1, ADDX6, 0, 0, 1, 5'd5, LUI5,  T_U,  1, 0);
        step("no_load",    1, ADDX6, 0, 0, 0, 5'd5, ADDX6, T_NO, 1, 0);
        // flush wins over hazard
        step("flush_haz",  1, ADDI,  1, 0, 1, 5'd5, ADDX6, T_NO, 1, 0);
        step("post_flush", 1, ADDX6, 0, 0, 0, 5'd0, NOP,   T_I,  0, 0);
        // hold frozen inside LU_STALL
        step("haz2",       1, SW,    0, 0, 1, 5'd5, ADDX6, T_NO, 1, 1);
        step("hold0",      1, SW,    0, 1, 1, 5'd5, ADDX6, T_NO, 1, 0);
        step("hold1",      1, SW,    0, 1, 1, 5'd5, ADDX6, T_NO, 1, 0);
`ifdef ID_PERF_CNT_EN
        cmp("cnt_hold.stall", stall_cnt, 32'd2);
`endif
        step("hold2",      1, SW,    0, 1, 1, 5'd5, ADDX6, T_NO, 1, 0);
        step("lu_release", 1, SW,    0, 0, 0, 5'd0, ADDX6, T_NO, 1, 0);
`ifdef ID_PERF_CNT_EN
        cmp("cnt.stall", stall_cnt, 32'd2);
        cmp("cnt.flush", flush_cnt, 32'd1);
`endif
        // back in RUN: a hazard on rs2 of the store stalls again
        step("run_haz",    1, ADDI,  0, 0, 1, 5'd1, SW,    T_S,  1, 1);
        // reset asserted mid-cycle while in LU_STALL
        drive(1, ADDI, 0, 0, 1, 5'd1);
        #2 rst_n = 1'b0;
        expect_now("rst_mid", NOP, T_I, 0, 0);
`ifdef ID_PERF_CNT_EN
        cmp("cnt_rst.stall", stall_cnt, 32'd0);
        cmp("cnt_rst.flush", flush_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_rel",    0, ADDI,  0, 0, 1, 5'd1, NOP,   T_I,  0, 0);
        step("rst_idle",   0, ADDI,  0, 0, 1, 5'd1, NOP,   T_I,  0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
